div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the execute stage beside the ALU. Its `result` drives the `e2` input of the write-back `Mux2x1`, whose `sel` is raised by control for M-extension divide ops. The control stalls the PC while `busy` is high and writes back on `done`.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. The design is verified at 32 only.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a divide. Accepted only when `busy`=0.
- `op`  in  2  instruction `funct3[1:0]`: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `a`  in  WIDTH  dividend (rs1). Sampled with `start`.
- `b`  in  WIDTH  divisor (rs2). Sampled with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  WIDTH  quotient or remainder. Held until the next accepted `start`.

## Operation
- States:
  - IDLE
  - CALC: WIDTH iterations.
  - FIX: sign correction and special cases.
  - DONE: one cycle. Behaves like IDLE for accepting `start`.
- Accept, when `start`=1 and state is IDLE or DONE:
  - Latch `op` and the operand signs.
  - Latch `|a|` and `|b|`. The absolute value applies for signed ops (`op[0]`=0) only; DIVU/REMU use the raw values.
  - Clear the remainder register and the iteration counter. Go to CALC.
- CALC performs one restoring step per cycle:
  - rem = {rem[WIDTH-2:0], dvd[WIDTH-1]}, then shift dvd left.
  - If rem ≥ divisor (unsigned compare, WIDTH+1-bit subtract), rem -= divisor and shift 1 into the quotient; otherwise shift 0.
  - After WIDTH steps, go to FIX.
- FIX selects the registered `result`:
  - Divisor = 0: quotient is all ones (-1 for DIV); remainder is the original `a`.
  - Signed quotient: negated if the sign of `a` ≠ the sign of `b`.
  - Signed remainder: negated if `a` is negative.
  - Overflow (DIV of 0x80000000 by 0xFFFFFFFF): quotient 0x80000000, remainder 0. The unsigned path followed by the sign rule produces this naturally and needs no special case.
  - Go to DONE.
- DONE: `done`=1 for one cycle.
  - With `start`=1, a new op is accepted in this same cycle; `done` still pulses.
  - Otherwise the block returns to IDLE.
- A `start` while `busy`=1 is ignored. The in-flight op is unaffected.
- Operand changes after acceptance are ignored.

## Timing
- Reset values (asynchronous, take effect immediately on `rst_n`=0): state IDLE, `busy`=0, `done`=0, `result`=0, all internal registers 0.
- Cycle 0 is the cycle in which `start`=1 is accepted.
- `busy`=1 in cycles 1..WIDTH+1 (CALC for WIDTH cycles, then FIX).
- `done`=1 and the new `result` appear in cycle WIDTH+2 (34 at WIDTH=32). `busy`=0 in that cycle.
- Back-to-back ops: a `start` in a DONE cycle gives its `done` WIDTH+2 cycles later.
- Reset mid-operation: the op is aborted. Outputs go to their reset values and no `done` is emitted.
- `result` is registered and changes only in the FIX→DONE transition or on reset. The combinational mux downstream sees a stable value.

## Configuration
- `DIV_ZERO_SHORTCUT_EN`, when defined:
  - A divisor of 0 at accept skips CALC and goes straight to FIX.
  - `busy`=1 in cycle 1 only; `done` in cycle 2.
- When undefined: a zero divisor takes the full WIDTH+2 latency.
- `result` values are identical in both builds.

## Test plan
- DIVU a=100, b=7 → `result`=14. Exactly one `done` pulse, in cycle 34. `busy` high in cycles 1–33.
- REM a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFF (-1). DIV with the same operands → 0xFFFFFFFD (-3).
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- Divide by zero:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - REM 0xFFFFFFFB/0 → 0xFFFFFFFB.
  - `done` in cycle 34 with the macro undefined, cycle 2 with it defined.
- Protocol:
  - Pulse `start` with new operands in cycle 10 of an op: the pulse is ignored and the original result is returned.
  - Issue `start` in the DONE cycle: the second result arrives 34 cycles later.
- Reset: assert `rst_n`=0 in cycle 15 of DIVU 1000/3. `busy`, `done` and `result` go to 0 immediately and no `done` follows. A fresh op after reset release returns 333.

Source files
------------

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_if
//  Description : Request/response bundle between execute-stage control and
//                the iterative divider. Control drives the master side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//                One quotient bit per cycle on magnitudes, sign fix-up and
//                divide-by-zero handling in a final FIX cycle.
//                Optional macro DIV_ZERO_SHORTCUT_EN: a zero divisor skips
//                the iteration phase (results are identical either way).
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    div_unit_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_fix  = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_a_raw;     // original dividend, returned as REM/REMU by zero
    logic [WIDTH-1:0] r_dvs;       // divisor magnitude
    logic [WIDTH-1:0] r_dq;        // dividend shifts out the top, quotient shifts in the bottom
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;

    logic             w_accept;
    logic             w_signed_in;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_signed_op;
    logic [WIDTH-1:0] w_quo_s;
    logic [WIDTH-1:0] w_rem_s;
    logic [WIDTH-1:0] w_fix_result;

    // DONE accepts a new request exactly like IDLE
    assign w_accept    = bus.start && ((r_state == c_idle) || (r_state == c_done));
    assign w_signed_in = ~bus.op[0];
    assign w_a_abs     = (w_signed_in && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    assign w_b_abs     = (w_signed_in && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

    // The shifted partial remainder keeps its carry-out bit so the compare
    // stays exact for divisors with the MSB set. When the subtract is taken
    // the true difference is below the divisor, so WIDTH bits suffice.
    assign w_rem_sh   = {r_rem, r_dq[WIDTH-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_dvs});
    assign w_rem_next = w_ge ? (w_rem_sh[WIDTH-1:0] - r_dvs) : w_rem_sh[WIDTH-1:0];

    // Sign correction and divide-by-zero selection for the FIX cycle.
    // Overflow (most-negative / -1) falls out of the magnitude path unaided.
    assign w_signed_op = ~r_op[0];
    assign w_quo_s     = (w_signed_op && (r_sign_a ^ r_sign_b)) ? (~r_dq + 1'b1) : r_dq;
    assign w_rem_s     = (w_signed_op && r_sign_a) ? (~r_rem + 1'b1) : r_rem;

    // Pick quotient or remainder; a zero divisor overrides the arithmetic
    always_comb begin
        w_fix_result = '0;
        if (r_div_zero) begin
            w_fix_result = r_op[1] ? r_a_raw : '1;
        end else begin
            w_fix_result = r_op[1] ? w_rem_s : w_quo_s;
        end
    end

    // Control FSM and iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_idle;
            r_op       <= '0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_div_zero <= 1'b0;
            r_a_raw    <= '0;
            r_dvs      <= '0;
            r_dq       <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
        end else if (w_accept) begin
            r_op       <= bus.op;
            r_sign_a   <= bus.a[WIDTH-1];
            r_sign_b   <= bus.b[WIDTH-1];
            r_div_zero <= (bus.b == '0);
            r_a_raw    <= bus.a;
            r_dvs      <= w_b_abs;
            r_dq       <= w_a_abs;
            r_rem      <= '0;
            r_cnt      <= '0;
`ifdef DIV_ZERO_SHORTCUT_EN
            r_state    <= (bus.b == '0) ? c_fix : c_calc;
`else
            r_state    <= c_calc;
`endif
        end else begin
            case (r_state)
                c_calc: begin
                    r_rem <= w_rem_next;
                    r_dq  <= {r_dq[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last_step) begin
                        r_state <= c_fix;
                    end
                end
                c_fix: begin
                    r_result <= w_fix_result;
                    r_state  <= c_done;
                end
                c_done: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.busy   = (r_state == c_calc) || (r_state == c_fix);
    assign bus.done   = (r_state == c_done);
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Directed self-checking bench for div_unit: arithmetic
//                vectors, divide-by-zero, overflow, busy/done timing,
//                ignored start, back-to-back issue and mid-op reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    localparam int WIDTH    = 32;
    localparam int FULL_LAT = WIDTH + 2;
`ifdef DIV_ZERO_SHORTCUT_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = WIDTH + 2;
`endif

    localparam logic [1:0] c_div  = 2'b00;
    localparam logic [1:0] c_divu = 2'b01;
    localparam logic [1:0] c_rem  = 2'b10;
    localparam logic [1:0] c_remu = 2'b11;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    div_unit_if #(.WIDTH(WIDTH)) bus ();

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus itself wedges
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request; called at a falling edge so the next rising edge accepts it
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    // Follow an issued op to its done pulse; returns at the falling edge of the done cycle.
    // poke_at > 0 raises start with junk operands during that busy cycle.
    task automatic wait_done(input string tag, input logic [31:0] exp_res,
                             input int exp_cyc, input int poke_at);
        int          cyc;
        int          done_cyc;
        bit          busy_bad;
        bit          hold_bad;
        logic [31:0] old;
        old      = bus.result;
        busy_bad = 1'b0;
        hold_bad = 1'b0;
        done_cyc = -1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.op    = 2'($urandom);
        cyc = 1;
        while (done_cyc < 0 && cyc <= 80) begin
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
            end else begin
                if (bus.busy !== 1'b1) busy_bad = 1'b1;
                if (bus.result !== old) hold_bad = 1'b1;
                if (cyc == poke_at) begin
                    bus.start = 1'b1;
                    bus.a     = $urandom;
                    bus.b     = $urandom;
                    bus.op    = 2'($urandom);
                end
                @(negedge clk);
                bus.start = 1'b0;
                cyc++;
            end
        end
        check({tag, " done_cycle"}, done_cyc, exp_cyc);
        check({tag, " busy_window"}, {31'd0, busy_bad}, 32'd0);
        check({tag, " result_held"}, {31'd0, hold_bad}, 32'd0);
        check({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " result"}, bus.result, exp_res);
    endtask

    initial begin
        bit seen;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        #1;
        check("reset busy",   {31'd0, bus.busy}, 32'd0);
        check("reset done",   {31'd0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic unsigned divide, plus single-cycle done pulse
        issue(c_divu, 32'd100, 32'd7);
        wait_done("divu_100_7", 32'd14, FULL_LAT, 0);
        @(negedge clk);
        check("divu_100_7 done_one_cycle", {31'd0, bus.done}, 32'd0);
        check("divu_100_7 result_after",   bus.result, 32'd14);

        // Signed remainder / quotient of -7 by 2
        issue(c_rem, 32'hFFFF_FFF9, 32'd2);
        wait_done("rem_m7_2", 32'hFFFF_FFFF, FULL_LAT, 0);
        issue(c_div, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_m7_2", 32'hFFFF_FFFD, FULL_LAT, 0);

        // Positive dividend, negative divisor
        issue(c_div, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_7_m2", 32'hFFFF_FFFD, FULL_LAT, 0);
        issue(c_rem, 32'd7, 32'hFFFF_FFFE);
        wait_done("rem_7_m2", 32'd1, FULL_LAT, 0);

        // Signed overflow
        issue(c_div, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 32'h8000_0000, FULL_LAT, 0);
        issue(c_rem, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("rem_ovf", 32'd0, FULL_LAT, 0);

        // Large unsigned operands exercise the remainder carry bit
        issue(c_divu, 32'hFFFF_FFFF, 32'h8000_0001);
        wait_done("divu_big", 32'd1, FULL_LAT, 0);
        issue(c_remu, 32'hFFFF_FFFF, 32'h8000_0001);
        wait_done("remu_big", 32'h7FFF_FFFE, FULL_LAT, 0);
        issue(c_divu, 32'hFFFF_FFFF, 32'd1);
        wait_done("divu_max_1", 32'hFFFF_FFFF, FULL_LAT, 0);

        // Divide by zero
        issue(c_div, 32'd5, 32'd0);
        wait_done("div_5_0", 32'hFFFF_FFFF, ZERO_LAT, 0);
        issue(c_remu, 32'd5, 32'd0);
        wait_done("remu_5_0", 32'd5, ZERO_LAT, 0);
        issue(c_rem, 32'hFFFF_FFFB, 32'd0);
        wait_done("rem_m5_0", 32'hFFFF_FFFB, ZERO_LAT, 0);

        // start while busy is ignored
        issue(c_divu, 32'd1000, 32'd7);
        wait_done("divu_poke", 32'd142, FULL_LAT, 10);

        // Back-to-back: second start lands in the DONE cycle of the first
        issue(c_div, 32'hFFFF_FF9C, 32'd7);
        wait_done("b2b_first", 32'hFFFF_FFF2, FULL_LAT, 0);
        issue(c_remu, 32'd1000, 32'd7);
        wait_done("b2b_second", 32'd6, FULL_LAT, 0);
        @(negedge clk);
        bus.start = 1'b0;

        // Reset in cycle 15 of DIVU 1000/3
        issue(c_divu, 32'd1000, 32'd3);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        check("pre_reset busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset busy",   {31'd0, bus.busy}, 32'd0);
        check("mid_reset done",   {31'd0, bus.done}, 32'd0);
        check("mid_reset result", bus.result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen = 1'b1;
        end
        check("post_reset no_done", {31'd0, seen}, 32'd0);
        issue(c_divu, 32'd1000, 32'd3);
        wait_done("divu_1000_3", 32'd333, FULL_LAT, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
